// File: rtl/vm_multi_item.sv
`default_nettype none
// ============================================================================
// Module   : vm_multi_item
// Purpose  : Vending-machine controller. It offers N_ITEMS = 2**ITEM_W items,
//            each with its own price. It accepts 10- and 50-unit coins up to a
//            credit cap, supports cancel with a full refund, and pays exact
//            change as a train of 10-unit return pulses.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1           clock; all state changes on posedge
//   rst            in   1           synchronous, active-high reset
//   item           in   ITEM_W      item index, qualified by sel
//   sel            in   1           purchase request (1-cycle pulse)
//   cancel         in   1           refund request (1-cycle pulse)
//   dollar_10      in   1           10-unit coin inserted (1-cycle pulse)
//   dollar_50      in   1           50-unit coin inserted (1-cycle pulse)
//   price          out  PRICE_W     price of the last selected item
//   credit         out  PRICE_W     current credit
//   item_rels      out  ITEM_W+1    {valid, index}; valid for one cycle per vend
//   change_return  out  1           one 10-unit coin returned per high cycle
//   coin_reject    out  1           the coin seen on the last edge was refused
//   busy           out  1           vend or change payout in progress
// ============================================================================
module vm_multi_item #(
  parameter int ITEM_W     = 2,
  parameter int PRICE_W    = 8,
  parameter logic [(2**ITEM_W)*PRICE_W-1:0] PRICES = {8'd50, 8'd40, 8'd30, 8'd20},
  parameter int CREDIT_MAX = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ITEM_W-1:0]   item,
  input  logic                sel,
  input  logic                cancel,
  input  logic                dollar_10,
  input  logic                dollar_50,
  output logic [PRICE_W-1:0]  price,
  output logic [PRICE_W-1:0]  credit,
  output logic [ITEM_W:0]     item_rels,
  output logic                change_return,
  output logic                coin_reject,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [PRICE_W:0]   CAP      = (PRICE_W+1)'(CREDIT_MAX);
  localparam logic [PRICE_W:0]   COIN_10  = (PRICE_W+1)'(10);
  localparam logic [PRICE_W:0]   COIN_50  = (PRICE_W+1)'(50);
  localparam logic [PRICE_W-1:0] CHANGE_1 = PRICE_W'(10);

  state_t              state, state_nxt;
  logic [PRICE_W-1:0]  credit_q, credit_nxt;
  logic [PRICE_W-1:0]  price_q, price_nxt;
  logic [ITEM_W-1:0]   index_q, index_nxt;
  logic                reject_q, reject_nxt;

  // The sums carry one extra bit so that an overflow past 2**PRICE_W-1 is
  // still seen as exceeding the cap.
  logic [PRICE_W:0]    sum_10, sum_50;
  logic [PRICE_W-1:0]  sel_price;
  logic [PRICE_W-1:0]  coin_credit;
  logic                coin_any;

  assign sum_10    = {1'b0, credit_q} + COIN_10;
  assign sum_50    = {1'b0, credit_q} + COIN_50;
  assign sel_price = PRICES[item*PRICE_W +: PRICE_W];
  assign coin_any  = dollar_10 | dollar_50;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      index_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit_q <= credit_nxt;
      price_q  <= price_nxt;
      index_q  <= index_nxt;
      reject_q <= reject_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    credit_nxt  = credit_q;
    price_nxt   = price_q;
    index_nxt   = index_q;
    reject_nxt  = 1'b0;
    coin_credit = credit_q;

    case (state)
      IDLE: begin
        // Coins are credited first. When both coins arrive together, the
        // 50 has priority and the 10 is always handed back.
        if (dollar_50) begin
          if (sum_50 <= CAP) coin_credit = sum_50[PRICE_W-1:0];
          else               reject_nxt  = 1'b1;
        end
        if (dollar_10) begin
          if (dollar_50)          reject_nxt  = 1'b1;
          else if (sum_10 <= CAP) coin_credit = sum_10[PRICE_W-1:0];
          else                    reject_nxt  = 1'b1;
        end
        credit_nxt = coin_credit;

        if (cancel) begin
          // Refund whatever credit is held once any same-edge coin is counted.
          if (coin_credit != '0) state_nxt = CHANGE;
        end else if (sel) begin
          price_nxt = sel_price;
          index_nxt = item;
          // Affordability uses the credit held before this edge.
          if (credit_q >= sel_price) state_nxt = VEND;
        end
      end

      VEND: begin
        reject_nxt = coin_any;
        credit_nxt = credit_q - price_q;
        state_nxt  = (credit_q != price_q) ? CHANGE : IDLE;
      end

      CHANGE: begin
        reject_nxt = coin_any;
        if (credit_q <= CHANGE_1) begin
          credit_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          credit_nxt = credit_q - CHANGE_1;
        end
      end

      default: begin
        reject_nxt = coin_any;
        state_nxt  = IDLE;
      end
    endcase
  end

  assign price         = price_q;
  assign credit        = credit_q;
  assign coin_reject   = reject_q;
  assign busy          = (state != IDLE);
  assign change_return = (state == CHANGE);
  assign item_rels     = (state == VEND) ? {1'b1, index_q} : '0;

endmodule
`default_nettype wire

// File: tb/tb_vm_multi_item.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm_multi_item
// Purpose  : Self-checking bench for vm_multi_item. A transaction-level model
//            keeps the idle credit and a queue of the per-cycle outputs that
//            the vend or refund sequence is expected to show.
// Revision : 1.0  initial release
// ============================================================================
module tb_vm_multi_item;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] item = '0;
  logic       sel = 1'b0, cancel = 1'b0, dollar_10 = 1'b0, dollar_50 = 1'b0;
  logic [7:0] price, credit;
  logic [2:0] item_rels;
  logic       change_return, coin_reject, busy;

  vm_multi_item dut (
    .clk(clk), .rst(rst), .item(item), .sel(sel), .cancel(cancel),
    .dollar_10(dollar_10), .dollar_50(dollar_50),
    .price(price), .credit(credit), .item_rels(item_rels),
    .change_return(change_return), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rels;
    int chg;
    int cr;
  } ev_t;

  int   prices[4] = '{20, 30, 40, 50};
  ev_t  sched[$];
  int   m_credit = 0;
  int   m_price  = 0;
  int   m_rej    = 0;
  int   total    = 0;
  int   bad      = 0;
  int   pulses   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_change(input int amount);
    for (int a = amount; a > 0; a -= 10) sched.push_back('{0, 1, a});
  endtask

  // One clock: check the outputs at the negedge, drive the next inputs, and
  // advance the model to what the following posedge should produce.
  task automatic cycle(input bit r, input bit s, input int it, input bit c,
                       input bit d10, input bit d50);
    int nc;
    @(negedge clk);
    if (sched.size() > 0) begin
      check("busy", int'(busy), 1);
      check("item_rels", int'(item_rels), sched[0].rels);
      check("change_return", int'(change_return), sched[0].chg);
      check("credit", int'(credit), sched[0].cr);
    end else begin
      check("busy", int'(busy), 0);
      check("item_rels", int'(item_rels), 0);
      check("change_return", int'(change_return), 0);
      check("credit", int'(credit), m_credit);
    end
    check("price", int'(price), m_price);
    check("coin_reject", int'(coin_reject), m_rej);
    if (change_return) pulses++;

    rst = r; sel = s; item = it[1:0]; cancel = c; dollar_10 = d10; dollar_50 = d50;

    if (r) begin
      sched.delete();
      m_credit = 0; m_price = 0; m_rej = 0;
    end else if (sched.size() > 0) begin
      m_rej = int'(d10 | d50);
      void'(sched.pop_front());
      if (sched.size() == 0) m_credit = 0;
    end else begin
      nc = m_credit;
      m_rej = 0;
      if (d50) begin
        if (m_credit + 50 <= 250) nc = m_credit + 50;
        else m_rej = 1;
      end
      if (d10) begin
        if (d50) m_rej = 1;
        else if (m_credit + 10 <= 250) nc = m_credit + 10;
        else m_rej = 1;
      end
      if (c) begin
        push_change(nc);
      end else if (s) begin
        m_price = prices[it];
        if (m_credit >= m_price) begin
          sched.push_back('{4 + it, 0, nc});
          push_change(nc - m_price);
        end
      end
      m_credit = nc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    // The first cycle checks the reset state.
    cycle(0, 0, 0, 0, 0, 0);

    // T1: 50 in, buy item 1 (30) -> vend 3'b101, two change pulses
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 0);
    idle(5);

    // T2: 10 in, item 3 unaffordable; 50 more, buy item 3 -> one pulse
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 3, 0, 0, 0);
    idle(4);

    // T3: 10 + 50 then cancel -> exactly six change pulses
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    pulses = 0;
    cycle(0, 0, 0, 1, 0, 0);
    idle(9);
    check("t3_pulses", pulses, 6);

    // T4: fill to 220, a further 50 is refused; then both coins from zero
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 0);
    idle(24);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0, 0);
    idle(7);

    // T5: coin during change payout; sel together with cancel refunds only
    cycle(0, 0, 0, 0, 0, 1);
    pulses = 0;
    cycle(0, 1, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 1, 0);
    idle(4);
    check("t5_pulses", pulses, 3);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 2, 1, 0, 0);
    idle(3);

    // T6: reset in the second change cycle, then start over from zero
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 0);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    idle(2);
    check("t6_credit", int'(credit), 50);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(199) == 0),
            ($urandom_range(5) == 0),
            int'($urandom_range(3)),
            ($urandom_range(19) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(5) == 0));
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
